// File: rtl/spimem_arb.sv
`timescale 1ns/1ps
// Round-robin arbiter of two read requesters onto one flash read port, with a one-word hit buffer and deferred config writes.
// Latency: hit 0 cycles; miss 1 arbitration cycle + flash latency; config write 2 cycles when no read is in flight.
// Backpressure: requesters hold valid until ready; a config write waits in IDLE until any in-flight read completes.
module spimem_arb #(
    parameter bit HIT_EN = 1'b1
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        m0_valid,
    output logic        m0_ready,
    input  logic [23:0] m0_addr,
    output logic [31:0] m0_rdata,

    input  logic        m1_valid,
    output logic        m1_ready,
    input  logic [23:0] m1_addr,
    output logic [31:0] m1_rdata,

    input  logic        cfg_valid,
    output logic        cfg_ready,
    input  logic [3:0]  cfg_we,
    input  logic [31:0] cfg_di,
    output logic [31:0] cfg_do,

    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [23:0] mem_addr,
    input  logic [31:0] mem_rdata,
    output logic [3:0]  mem_cfgreg_we,
    output logic [31:0] mem_cfgreg_di,
    input  logic [31:0] mem_cfgreg_do
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        CFG  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;

    // rr_last: 0 = m0 won last, 1 = m1 won last. grant: requester owning the XFER.
    logic        rr_last;
    logic        grant;
    logic        buf_valid;
    logic [23:0] buf_addr;
    logic [31:0] buf_data;

    logic        win;
    logic [23:0] win_addr;
    logic        any_req;
    logic        hit;
    logic        rr_upd;
    logic        load_grant;
    logic        fill_buf;
    logic        inval_buf;

    // Readback is a straight passthrough; it never depends on arbitration state.
    assign cfg_do  = mem_cfgreg_do;
    assign any_req = m0_valid | m1_valid;
    assign hit     = HIT_EN && buf_valid && (win_addr == buf_addr);

    // Winner selection: on a tie the requester that did not win last goes next.
    always_comb begin
        win = 1'b0;
        if (m0_valid && m1_valid) begin
            win = ~rr_last;
        end else if (m1_valid) begin
            win = 1'b1;
        end
        win_addr = win ? m1_addr : m0_addr;
    end

    // State register; async reset drops mem_valid immediately and abandons any transfer.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and all handshake outputs; read data is forced to zero unless its ready is high.
    always_comb begin
        state_nxt     = state;
        m0_ready      = 1'b0;
        m1_ready      = 1'b0;
        m0_rdata      = 32'd0;
        m1_rdata      = 32'd0;
        cfg_ready     = 1'b0;
        mem_valid     = 1'b0;
        mem_cfgreg_we = 4'd0;
        mem_cfgreg_di = 32'd0;
        rr_upd        = 1'b0;
        load_grant    = 1'b0;
        fill_buf      = 1'b0;
        inval_buf     = 1'b0;
        case (state)
            IDLE: begin
                // A pending config write blocks both new grants and hit service.
                if (cfg_valid) begin
                    state_nxt = CFG;
                end else if (any_req) begin
                    rr_upd = 1'b1;
                    if (hit) begin
                        if (win) begin
                            m1_ready = 1'b1;
                            m1_rdata = buf_data;
                        end else begin
                            m0_ready = 1'b1;
                            m0_rdata = buf_data;
                        end
                    end else begin
                        load_grant = 1'b1;
                        state_nxt  = XFER;
                    end
                end
            end
            XFER: begin
                mem_valid = 1'b1;
                if (mem_ready) begin
                    // The buffer fills even if the owner has withdrawn; only the ready is suppressed.
                    fill_buf  = 1'b1;
                    state_nxt = IDLE;
                    if (grant) begin
                        if (m1_valid) begin
                            m1_ready = 1'b1;
                            m1_rdata = mem_rdata;
                        end
                    end else begin
                        if (m0_valid) begin
                            m0_ready = 1'b1;
                            m0_rdata = mem_rdata;
                        end
                    end
                end
            end
            CFG: begin
                // Single-cycle write; a zero byte mask is still a full handshake.
                mem_cfgreg_we = cfg_we;
                mem_cfgreg_di = cfg_di;
                cfg_ready     = 1'b1;
                inval_buf     = 1'b1;
                state_nxt     = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Arbitration history, granted address and hit buffer contents.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rr_last   <= 1'b1;
            grant     <= 1'b0;
            mem_addr  <= 24'd0;
            buf_valid <= 1'b0;
            buf_addr  <= 24'd0;
            buf_data  <= 32'd0;
        end else begin
            if (rr_upd) begin
                rr_last <= win;
            end
            if (load_grant) begin
                grant    <= win;
                mem_addr <= win_addr;
            end
            if (fill_buf) begin
                buf_addr  <= mem_addr;
                buf_data  <= mem_rdata;
                buf_valid <= HIT_EN;
            end else if (inval_buf) begin
                buf_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spimem_arb.sv
`timescale 1ns/1ps
// Bench for spimem_arb: randomized reads/config writes against a transaction-level model.
// Latency: checks hit, miss, config and deferral timing in cycles from request.
// Backpressure: requesters hold valid until ready, as the protocol requires.
module tb_spimem_arb;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    always #5 clk = ~clk;

    logic        m0_valid, m0_ready, m1_valid, m1_ready;
    logic [23:0] m0_addr, m1_addr;
    logic [31:0] m0_rdata, m1_rdata;
    logic        cfg_valid, cfg_ready;
    logic [3:0]  cfg_we;
    logic [31:0] cfg_di, cfg_do;
    logic        mem_valid, mem_ready;
    logic [23:0] mem_addr;
    logic [31:0] mem_rdata;
    logic [3:0]  mem_cfgreg_we;
    logic [31:0] mem_cfgreg_di, mem_cfgreg_do;

    // Second instance with the hit buffer disabled and a zero-wait flash.
    logic        h_m0_valid, h_m0_ready, h_m1_ready, h_cfg_ready;
    logic [23:0] h_m0_addr, h_mem_addr;
    logic [31:0] h_m0_rdata, h_m1_rdata, h_cfg_do, h_mem_rdata, h_mem_cfgreg_di;
    logic        h_mem_valid, h_mem_ready;
    logic [3:0]  h_mem_cfgreg_we;

    int checks = 0;
    int failures = 0;

    // Flash data is a fixed function of the address.
    function automatic logic [31:0] fdata(input logic [23:0] a);
        return {~a[7:0], a} ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [23:0] pool(input int k);
        return 24'h100000 + 24'(4 * k);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    spimem_arb #(.HIT_EN(1'b1)) dut (
        .clk(clk), .resetn(resetn),
        .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_addr(m0_addr), .m0_rdata(m0_rdata),
        .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_addr(m1_addr), .m1_rdata(m1_rdata),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_we(cfg_we), .cfg_di(cfg_di), .cfg_do(cfg_do),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .mem_cfgreg_we(mem_cfgreg_we), .mem_cfgreg_di(mem_cfgreg_di), .mem_cfgreg_do(mem_cfgreg_do)
    );

    assign h_mem_ready = h_mem_valid;
    assign h_mem_rdata = fdata(h_mem_addr);

    spimem_arb #(.HIT_EN(1'b0)) dut_nohit (
        .clk(clk), .resetn(resetn),
        .m0_valid(h_m0_valid), .m0_ready(h_m0_ready), .m0_addr(h_m0_addr), .m0_rdata(h_m0_rdata),
        .m1_valid(1'b0), .m1_ready(h_m1_ready), .m1_addr(24'd0), .m1_rdata(h_m1_rdata),
        .cfg_valid(1'b0), .cfg_ready(h_cfg_ready), .cfg_we(4'd0), .cfg_di(32'd0), .cfg_do(h_cfg_do),
        .mem_valid(h_mem_valid), .mem_ready(h_mem_ready), .mem_addr(h_mem_addr), .mem_rdata(h_mem_rdata),
        .mem_cfgreg_we(h_mem_cfgreg_we), .mem_cfgreg_di(h_mem_cfgreg_di), .mem_cfgreg_do(32'h0BAD_F00D)
    );

    // Flash responder: completes flash_lat cycles after mem_valid rises, garbage data otherwise.
    int flash_lat = 4;
    int fcnt = 0;
    initial begin
        mem_ready = 1'b0;
        mem_rdata = 32'd0;
        forever begin
            @(posedge clk);
            #1;
            if (!resetn || !mem_valid) begin
                fcnt = 0;
                mem_ready = 1'b0;
                mem_rdata = $urandom;
            end else begin
                fcnt++;
                mem_ready = (fcnt == flash_lat);
                mem_rdata = mem_ready ? fdata(mem_addr) : $urandom;
            end
        end
    end

    // Monitor: event counters plus per-cycle protocol invariants.
    int mv_cycles = 0, xfers = 0, h_xfers = 0, we_cycles = 0;
    logic [23:0] xfer_q[$];
    initial begin
        forever begin
            @(negedge clk);
            if (!resetn) begin
                chk("rst_outs", {26'd0, mem_valid, m0_ready, m1_ready, cfg_ready, |mem_cfgreg_we, 1'b0}, 32'd0);
            end else begin
                if (mem_valid) mv_cycles++;
                if (mem_valid && mem_ready) begin
                    xfers++;
                    xfer_q.push_back(mem_addr);
                end
                if (h_mem_valid && h_mem_ready) h_xfers++;
                if (mem_cfgreg_we != 4'd0) begin
                    we_cycles++;
                    chk("cfgwe_without_rdy", 32'(cfg_ready), 32'd1);
                end
            end
            if (!m0_ready) chk("m0_rdata_idle", m0_rdata, 32'd0);
            if (!m1_ready) chk("m1_rdata_idle", m1_rdata, 32'd0);
            if (!h_m0_ready) chk("h_m0_rdata_idle", h_m0_rdata, 32'd0);
            chk("one_ready", 32'(m0_ready & m1_ready), 32'd0);
            chk("cfg_do", cfg_do, mem_cfgreg_do);
            chk("h_quiet", {26'd0, h_m1_ready, h_cfg_ready, h_mem_cfgreg_we} | h_m1_rdata | h_mem_cfgreg_di, 32'd0);
            chk("h_cfg_do", h_cfg_do, 32'h0BAD_F00D);
        end
    end

    // Reference model state: buffer contents and the last winner (1 = m1).
    bit          m_bv = 1'b0;
    logic [23:0] m_ba = 24'd0;
    logic [31:0] m_bd = 32'd0;
    int          m_last = 1;
    logic [23:0] uniq = 24'h200000;

    task automatic rd(input int p, input logic [23:0] a, output int lat, output logic [31:0] d);
        bit got = 1'b0;
        lat = -1;
        d = 32'd0;
        @(posedge clk);
        #1;
        if (p == 0) begin m0_valid = 1'b1; m0_addr = a; end
        else begin m1_valid = 1'b1; m1_addr = a; end
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if ((p == 0) ? m0_ready : m1_ready) begin
                got = 1'b1;
                lat = i;
                d = (p == 0) ? m0_rdata : m1_rdata;
            end
            @(posedge clk);
            #1;
        end
        if (p == 0) m0_valid = 1'b0; else m1_valid = 1'b0;
        if (!got) chk("rd_timeout", 32'd0, 32'd1);
    endtask

    task automatic model_rd(input int p, input logic [23:0] a, input int lf);
        int lat;
        int x0;
        bit h;
        logic [31:0] d;
        flash_lat = lf;
        x0 = xfers;
        h = m_bv && (m_ba == a);
        rd(p, a, lat, d);
        if (h) begin
            chk("hit_lat", lat, 32'd0);
            chk("hit_data", d, m_bd);
            chk("hit_noflash", xfers - x0, 32'd0);
        end else begin
            chk("miss_lat", lat, lf);
            chk("miss_data", d, fdata(a));
            chk("miss_flash", xfers - x0, 32'd1);
            m_bv = 1'b1;
            m_ba = a;
            m_bd = fdata(a);
        end
        m_last = p;
    endtask

    task automatic cfg_wr(input logic [3:0] we, input logic [31:0] di, output int lat);
        bit got = 1'b0;
        int w0;
        w0 = we_cycles;
        lat = -1;
        @(posedge clk);
        #1;
        cfg_valid = 1'b1;
        cfg_we = we;
        cfg_di = di;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (cfg_ready) begin
                got = 1'b1;
                lat = i;
                chk("cfg_we_out", 32'(mem_cfgreg_we), 32'(we));
                chk("cfg_di_out", mem_cfgreg_di, di);
            end
            @(posedge clk);
            #1;
        end
        cfg_valid = 1'b0;
        cfg_we = 4'd0;
        if (!got) chk("cfg_timeout", 32'd0, 32'd1);
        chk("cfg_we_cycles", we_cycles - w0, (we != 4'd0) ? 32'd1 : 32'd0);
        m_bv = 1'b0;
    endtask

    // Both requesters continuously valid with fresh missing addresses; grants must alternate.
    task automatic rr_run(input int n, input int lf);
        logic [23:0] cur [2];
        int exp_p, k, last_i, done_p;
        bit fire;
        flash_lat = lf;
        exp_p = (m_last == 1) ? 0 : 1;
        k = 0;
        last_i = -1;
        done_p = 0;
        fire = 1'b0;
        @(posedge clk);
        #1;
        xfer_q.delete();
        uniq += 24'd4; cur[0] = uniq;
        uniq += 24'd4; cur[1] = uniq;
        m0_addr = cur[0];
        m1_addr = cur[1];
        m0_valid = 1'b1;
        m1_valid = 1'b1;
        for (int i = 0; i < n * (lf + 1) + 20 && k < n; i++) begin
            @(negedge clk);
            if (m0_ready || m1_ready) begin
                done_p = m1_ready ? 1 : 0;
                chk("rr_order", done_p, exp_p);
                chk("rr_data", (done_p == 1) ? m1_rdata : m0_rdata, fdata(cur[done_p]));
                chk("rr_gap", i - last_i, lf + 1);
                last_i = i;
                k++;
                fire = 1'b1;
                m_bv = 1'b1;
                m_ba = cur[done_p];
                m_bd = fdata(cur[done_p]);
                m_last = done_p;
                exp_p = 1 - done_p;
            end
            @(posedge clk);
            #1;
            if (fire) begin
                fire = 1'b0;
                chk("rr_mem_addr", (xfer_q.size() > 0) ? 32'(xfer_q.pop_front()) : 32'hFFFF_FFFF, 32'(cur[done_p]));
                uniq += 24'd4;
                cur[done_p] = uniq;
                if (done_p == 1) m1_addr = cur[1]; else m0_addr = cur[0];
            end
        end
        m0_valid = 1'b0;
        m1_valid = 1'b0;
        chk("rr_grants", k, n);
    endtask

    int          lat_a, lat_b, mv0, x0, op;
    logic [31:0] d_a;
    bit          got;

    initial begin
        m0_valid = 1'b0; m0_addr = 24'd0;
        m1_valid = 1'b0; m1_addr = 24'd0;
        cfg_valid = 1'b0; cfg_we = 4'd0; cfg_di = 32'd0;
        mem_cfgreg_do = 32'hC0FF_EE01;
        h_m0_valid = 1'b0; h_m0_addr = 24'd0;

        // Reset state
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_mem_addr", 32'(mem_addr), 32'd0);
            chk("rst_mem_valid", 32'(mem_valid), 32'd0);
        end
        @(posedge clk);
        #1;
        resetn = 1'b1;

        // Fairness right after reset: m0 wins the first tie.
        rr_run(4, 3);

        // Long miss then zero-latency hit of the same word
        mv0 = mv_cycles;
        model_rd(0, pool(0), 20);
        chk("miss_mv_cycles", mv_cycles - mv0, 32'd20);
        mv0 = mv_cycles;
        model_rd(0, pool(0), 20);
        chk("hit_mv_cycles", mv_cycles - mv0, 32'd0);

        // Config write raised during an m1 transfer is deferred until it completes.
        flash_lat = 10;
        fork
            model_rd(1, pool(1), 10);
            begin
                repeat (3) @(posedge clk);
                cfg_wr(4'b1000, 32'hA5A5_0001, lat_b);
            end
        join
        chk("cfg_defer_lat", lat_b, 32'd9);
        model_rd(1, pool(1), 4);

        // Simultaneous config and would-be hit: config first, then the read misses.
        model_rd(0, pool(2), 3);
        x0 = xfers;
        fork
            cfg_wr(4'b0000, 32'h1234_5678, lat_b);
            rd(0, pool(2), lat_a, d_a);
        join
        chk("cfg_first_lat", lat_b, 32'd1);
        chk("cfg_then_miss_lat", lat_a, 32'd5);
        chk("cfg_then_miss_data", d_a, fdata(pool(2)));
        chk("cfg_then_miss_flash", xfers - x0, 32'd1);
        m_bv = 1'b1; m_ba = pool(2); m_bd = fdata(pool(2)); m_last = 0;

        // Hit buffer disabled: repeated reads both go to flash.
        h_m0_addr = 24'h123450;
        for (int r = 0; r < 2; r++) begin
            @(posedge clk);
            #1;
            h_m0_valid = 1'b1;
            got = 1'b0;
            for (int i = 0; i < 20 && !got; i++) begin
                @(negedge clk);
                if (h_m0_ready) begin
                    got = 1'b1;
                    chk("nohit_lat", i, 32'd1);
                    chk("nohit_data", h_m0_rdata, fdata(24'h123450));
                end
                @(posedge clk);
                #1;
            end
            h_m0_valid = 1'b0;
            if (!got) chk("nohit_timeout", 32'd0, 32'd1);
        end
        chk("nohit_xfers", h_xfers, 32'd2);

        // Randomized mix of reads over a small address pool, config writes and contention.
        for (int it = 0; it < 40; it++) begin
            op = int'($urandom_range(0, 5));
            if (op <= 3) begin
                model_rd(int'($urandom_range(0, 1)), pool(int'($urandom_range(0, 3))), int'($urandom_range(1, 5)));
            end else if (op == 4) begin
                cfg_wr(4'($urandom), $urandom, lat_b);
                chk("cfg_lat", lat_b, 32'd1);
            end else begin
                rr_run(2, int'($urandom_range(1, 4)));
            end
        end

        // Async reset in the middle of a transfer
        flash_lat = 20;
        @(posedge clk);
        #1;
        m0_valid = 1'b1;
        m0_addr = pool(3) + 24'h000100;
        repeat (5) @(posedge clk);
        #3;
        resetn = 1'b0;
        #1;
        chk("arst_mem_valid", 32'(mem_valid), 32'd0);
        chk("arst_m0_ready", 32'(m0_ready), 32'd0);
        m0_valid = 1'b0;
        @(posedge clk);
        #3;
        resetn = 1'b1;
        mv0 = mv_cycles;
        got = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (m0_ready || m1_ready) got = 1'b1;
        end
        chk("arst_no_ready", 32'(got), 32'd0);
        chk("arst_no_xfer", mv_cycles - mv0, 32'd0);
        m_bv = 1'b0;
        m_last = 1;
        model_rd(1, pool(3) + 24'h000100, 4);
        rr_run(2, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spimem_arb.md
# spimem_arb

Two-requester arbiter and configuration sequencer in front of the QSPI flash read controller in PicoSoC. It shares the controller's single valid/ready read port between the instruction-fetch and data buses using round-robin arbitration. A one-word hit buffer returns repeated reads of the same word without a flash access. Configuration-register writes are deferred until no read is in flight, so a soft reset of the flash engine never cuts a transfer in half.

## Interface

Parameters:
- HIT_EN, 1, enables the one-word hit buffer; 0 forces every read to the flash port.

Ports:
- clk  in  1  clock, all state on rising edge
- resetn  in  1  asynchronous, active-low reset
- m0_valid  in  1  instruction-fetch request; held until m0_ready
- m0_ready  out  1  m0 completion strobe, one cycle
- m0_addr  in  24  m0 byte address, word aligned
- m0_rdata  out  32  m0 read data, valid with m0_ready, else 0
- m1_valid / m1_ready / m1_addr / m1_rdata  same as m0, data bus
- cfg_valid  in  1  config-write request; held until cfg_ready
- cfg_ready  out  1  config-write completion strobe
- cfg_we  in  4  byte write enables for the config register
- cfg_di  in  32  config write data
- cfg_do  out  32  config readback, combinational passthrough of mem_cfgreg_do
- mem_valid  out  1  read request to flash controller
- mem_ready  in  1  flash controller completion (may be combinational on mem_valid)
- mem_addr  out  24  latched granted address
- mem_rdata  in  32  flash read data, valid with mem_ready
- mem_cfgreg_we  out  4  config byte enables to flash controller
- mem_cfgreg_di  out  32  config data to flash controller
- mem_cfgreg_do  in  32  config readback from flash controller

## Operation

- States: IDLE, XFER, CFG.
- IDLE, priority order:
  - cfg_valid: go to CFG. No read is granted and no hit is served that cycle.
  - Otherwise pick a winner among the valid mN:
    - If both are valid, the winner is the one not marked in rr_last.
    - If only one is valid, that one wins.
  - Winner hit (HIT_EN && buf_valid && addr == buf_addr):
    - Assert winner ready combinationally this cycle, with rdata = buf_data.
    - Set rr_last = winner. Stay in IDLE.
  - Winner miss:
    - Latch addr into mem_addr and latch grant = winner.
    - Set rr_last = winner. Go to XFER.
- XFER:
  - mem_valid = 1.
  - When mem_ready:
    - Granted ready = mem_ready && granted valid.
    - Granted rdata = mem_rdata.
    - buf_addr <= mem_addr; buf_data <= mem_rdata; buf_valid <= HIT_EN.
    - Go to IDLE.
  - If the granted requester drops valid mid-transfer: the transfer still completes and fills the buffer, and no ready is issued.
  - The non-granted requester sees ready = 0.
- CFG (exactly one cycle):
  - mem_cfgreg_we = cfg_we and mem_cfgreg_di = cfg_di.
  - cfg_ready = 1.
  - buf_valid <= 0. Go to IDLE.
  - mem_cfgreg_we is 0 in every other state.
  - cfg_we = 0 is legal: a one-cycle no-op handshake that still invalidates the buffer.
- cfg_valid arriving during XFER waits until the XFER completes.
- Address compare is the full 24 bits. No address arithmetic is performed.

## Timing

- Reset (async assert, sync-release usage assumed upstream):
  - state = IDLE, rr_last = 1 (m0 wins the first tie), buf_valid = 0.
  - buf_addr = 0, buf_data = 0, mem_addr = 0.
- Outputs during and right after reset:
  - mem_valid = 0, m0_ready = m1_ready = cfg_ready = 0.
  - mem_cfgreg_we = 0, m0_rdata = m1_rdata = 0.
- Hit latency: 0 cycles. Ready is asserted in the same cycle valid is seen in IDLE.
- Miss latency: 1 cycle of arbitration plus flash latency. Ready is asserted in the cycle mem_ready is high.
- Config latency: 1 cycle of IDLE decision plus 1 cycle in CFG (cfg_ready in the second cycle) when no read is in flight.
- Back-to-back reads: after XFER completes, IDLE re-arbitrates on the next cycle. Max flash-port duty is one transfer per (flash latency + 1) cycles.
- Fairness: with both requesters continuously valid and missing, grants alternate m0, m1, m0, ...
- Reset asserted in XFER: mem_valid drops asynchronously, the in-flight result is discarded, and the buffer is invalid after reset.

## Test plan

- Single miss then hit:
  - m0 reads 0x100000 and flash returns 0xDEADBEEF after 20 cycles: m0_ready once with 0xDEADBEEF, mem_valid high for exactly those 20 cycles.
  - m0 re-reads 0x100000: ready in the same cycle, mem_valid stays 0.
- Round-robin: m0 and m1 both continuously valid with distinct missing addresses. Grant order after reset is m0, m1, m0, m1, and mem_addr matches each grant.
- Config deferral:
  - cfg_valid with we = 4'b1000 raised 3 cycles into an m1 XFER: mem_cfgreg_we stays 0 until m1_ready.
  - Then exactly one cycle of we = 4'b1000 with cfg_ready.
  - The following read of the previously buffered address misses.
- Simultaneous cfg_valid and m0 hit in IDLE: cfg served first with m0_ready = 0. m0 is then served as a miss from flash.
- HIT_EN = 0: m0 reads the same address twice and two full flash transfers occur.
- Async reset mid-XFER: resetn low for 1 cycle at cycle 5 of a transfer.
  - mem_valid falls immediately and no ready is issued.
  - The next m1 request wins the first tie against m0 = 0, and the buffer is empty.
